// File: rtl/mini_cpu_pkg.sv
// rtl/mini_cpu_pkg.sv - shared widths, op-code encoding and FSM state type for the execute stage
package mini_cpu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int REG_AW_DEF = 3;

  typedef logic [3:0] op_t;

  localparam op_t OP_ADD = 4'd0;
  localparam op_t OP_SUB = 4'd1;
  localparam op_t OP_AND = 4'd2;
  localparam op_t OP_OR  = 4'd3;
  localparam op_t OP_XOR = 4'd4;
  localparam op_t OP_SHL = 4'd5;
  localparam op_t OP_SHR = 4'd6;
  localparam op_t OP_MOV = 4'd7;
  localparam op_t OP_MUL = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  function automatic logic op_is_legal(input op_t op);
    return op <= OP_MUL;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - decoder issue handshake, register-file write-back and flag bundle
interface alu_exec_unit_if
  import mini_cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
);

  logic              issue_valid;
  logic              issue_ready;
  op_t               op;
  logic [REG_AW-1:0] rd_in;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              wb_we;
  logic [REG_AW-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic              flag_z;
  logic              flag_c;
  logic              busy;
  logic              illegal_op;

  modport master (
    output issue_valid, op, rd_in, a, b,
    input  issue_ready, wb_we, wb_rd, wb_data, flag_z, flag_c, busy, illegal_op
  );

  modport slave (
    input  issue_valid, op, rd_in, a, b,
    output issue_ready, wb_we, wb_rd, wb_data, flag_z, flag_c, busy, illegal_op
  );

endinterface

// File: rtl/alu_exec_unit_seq_multiplier.sv
// rtl/alu_exec_unit_seq_multiplier.sv - iterative shift-add multiplier, one partial product per clock
module seq_multiplier #(
  parameter int W = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_start,
  input  logic [W-1:0]   i_mcand,
  input  logic [W-1:0]   i_mplier,
  output logic           o_done,
  output logic [2*W-1:0] o_product
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic           r_run;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [2*W-1:0] r_acc;

  logic [2*W-1:0] w_partial;
  logic [2*W-1:0] w_sum;

  assign w_partial = r_mplier[0] ? r_mcand : '0;
  assign w_sum     = r_acc + w_partial;

  // Product is taken combinationally on the last step so the caller can register it on that same edge.
  assign o_done    = r_run && (r_cnt == CW'(W - 1));
  assign o_product = w_sum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run    <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_run    <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= {{W{1'b0}}, i_mcand};
      r_mplier <= i_mplier;
      r_acc    <= '0;
    end else if (r_run) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (r_cnt == CW'(W - 1)) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute stage: single-cycle ALU, iterative MUL, flags and register-file write-back
module alu_exec_unit
  import mini_cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  alu_exec_unit_if.slave bus
);

  state_e r_state;
  state_e w_state_nxt;

  logic              r_started;
  logic              r_wb_we;
  logic [REG_AW-1:0] r_wb_rd;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_flag_z;
  logic              r_flag_c;
  logic              r_illegal;
  logic [REG_AW-1:0] r_mul_rd;

  logic              w_issue_ready;
  logic              w_busy;
  logic              w_accept;
  logic              w_is_mul;
  logic              w_mul_start;
  logic              w_mul_done;
  logic [2*DATA_W-1:0] w_product;

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_res;
  logic              w_c;
  logic              w_legal;

  assign w_accept    = bus.issue_valid && w_issue_ready;
  assign w_is_mul    = (bus.op == OP_MUL);
  assign w_mul_start = w_accept && w_is_mul;

  seq_multiplier #(.W(DATA_W)) u_mul (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (w_mul_start),
    .i_mcand   (bus.a),
    .i_mplier  (bus.b),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_mul_start) w_state_nxt = ST_MUL;
      ST_MUL:  if (w_mul_done)  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // r_started keeps issue_ready low until the first edge after reset release.
  always_comb begin
    w_issue_ready = (r_state == ST_IDLE) && r_started;
    w_busy        = (r_state == ST_MUL);
  end

  assign w_sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign w_diff = {1'b0, bus.a} - {1'b0, bus.b};

  always_comb begin
    w_res   = '0;
    w_c     = r_flag_c;
    w_legal = op_is_legal(bus.op);
    case (bus.op)
      OP_ADD: begin w_res = w_sum[DATA_W-1:0];  w_c = w_sum[DATA_W];  end
      OP_SUB: begin w_res = w_diff[DATA_W-1:0]; w_c = w_diff[DATA_W]; end
      OP_AND: begin w_res = bus.a & bus.b; w_c = 1'b0; end
      OP_OR:  begin w_res = bus.a | bus.b; w_c = 1'b0; end
      OP_XOR: begin w_res = bus.a ^ bus.b; w_c = 1'b0; end
      OP_SHL: begin w_res = bus.a << 1; w_c = bus.a[DATA_W-1]; end
      OP_SHR: begin w_res = bus.a >> 1; w_c = bus.a[0]; end
      OP_MOV: w_res = bus.b;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_started <= 1'b0;
      r_wb_we   <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
      r_flag_z  <= 1'b0;
      r_flag_c  <= 1'b0;
      r_illegal <= 1'b0;
      r_mul_rd  <= '0;
    end else begin
      r_started <= 1'b1;
      r_wb_we   <= 1'b0;
      r_illegal <= 1'b0;
      if (w_accept && w_is_mul) begin
        r_mul_rd <= bus.rd_in;
      end else if (w_accept && w_legal) begin
        r_wb_we   <= 1'b1;
        r_wb_rd   <= bus.rd_in;
        r_wb_data <= w_res;
        r_flag_z  <= (w_res == '0);
        r_flag_c  <= w_c;
      end else if (w_accept) begin
        r_illegal <= 1'b1;
      end else if (w_mul_done) begin
        r_wb_we   <= 1'b1;
        r_wb_rd   <= r_mul_rd;
        r_wb_data <= w_product[DATA_W-1:0];
        r_flag_z  <= (w_product[DATA_W-1:0] == '0);
        r_flag_c  <= |w_product[2*DATA_W-1:DATA_W];
      end
    end
  end

  assign bus.issue_ready = w_issue_ready;
  assign bus.busy        = w_busy;
  assign bus.wb_we       = r_wb_we;
  assign bus.wb_rd       = r_wb_rd;
  assign bus.wb_data     = r_wb_data;
  assign bus.flag_z      = r_flag_z;
  assign bus.flag_c      = r_flag_c;
  assign bus.illegal_op  = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - vector table, corner sequences and randomized ops against an arithmetic model
module tb_alu_exec_unit;
  import mini_cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic m_c;
  logic m_z;

  alu_exec_unit_if bus ();

  alu_exec_unit dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] rd;
    logic       we;
    logic       ill;
    logic [7:0] d;
    logic       c;
    logic       z;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic we, output logic ill, output logic [7:0] d,
                       output logic c, output logic z);
    int s;
    int p;
    we = 1'b1; ill = 1'b0; c = m_c; d = 8'h00;
    case (op)
      4'd0: begin s = int'(a) + int'(b); d = 8'(s); c = (s > 255); end
      4'd1: begin s = int'(a) - int'(b); d = 8'(s); c = (a < b); end
      4'd2: begin d = a & b; c = 1'b0; end
      4'd3: begin d = a | b; c = 1'b0; end
      4'd4: begin d = a ^ b; c = 1'b0; end
      4'd5: begin s = int'(a) * 2; d = 8'(s); c = (a >= 8'h80); end
      4'd6: begin d = a / 2; c = (a % 2) == 1; end
      4'd7: d = b;
      4'd8: begin p = int'(a) * int'(b); d = 8'(p); c = (p > 255); end
      default: begin we = 1'b0; ill = 1'b1; end
    endcase
    z = we ? (d == 8'h00) : m_z;
  endtask

  task automatic exec(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [2:0] rd,
                      input logic we_e, input logic ill_e, input logic [7:0] d_e,
                      input logic c_e, input logic z_e);
    int n;
    n = 0;
    while (!bus.issue_ready && n < 20) begin tick(); n++; end
    check("ready_before_issue", bus.issue_ready, 1);
    bus.issue_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.rd_in = rd;
    tick();
    bus.issue_valid = 1'b0;
    if (op == OP_MUL) begin
      bus.a = ~a; bus.b = ~b; bus.op = OP_ADD; bus.rd_in = ~rd;
      n = 0;
      while (!bus.wb_we && n < 20) begin
        check("mul_busy", bus.busy, 1);
        check("mul_ready_low", bus.issue_ready, 0);
        tick();
        n++;
      end
      check("mul_latency", n, 8);
      check("mul_ready_back", bus.issue_ready, 1);
    end
    check("wb_we", bus.wb_we, we_e);
    check("illegal_op", bus.illegal_op, ill_e);
    if (we_e) begin
      check("wb_data", bus.wb_data, d_e);
      check("wb_rd", bus.wb_rd, rd);
    end
    check("flag_c", bus.flag_c, c_e);
    check("flag_z", bus.flag_z, z_e);
    m_c = c_e;
    m_z = z_e;
    tick();
    check("wb_we_single", bus.wb_we, 0);
    check("illegal_single", bus.illegal_op, 0);
  endtask

  initial begin
    logic       we, ill, c, z, seen_we;
    logic [7:0] d, ra, rb;
    logic [3:0] rop;
    logic [2:0] rrd;

    errors = 0; checks = 0; m_c = 1'b0; m_z = 1'b0;
    bus.issue_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.rd_in = '0;

    tbl[0]  = '{4'd0,  8'hF0, 8'h20, 3'd1, 1'b1, 1'b0, 8'h10, 1'b1, 1'b0};
    tbl[1]  = '{4'd1,  8'h05, 8'h05, 3'd2, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[2]  = '{4'd4,  8'hAA, 8'hFF, 3'd3, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0};
    tbl[3]  = '{4'd8,  8'h13, 8'h11, 3'd4, 1'b1, 1'b0, 8'h43, 1'b1, 1'b0};
    tbl[4]  = '{4'd12, 8'h00, 8'h00, 3'd5, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[5]  = '{4'd7,  8'h3C, 8'h00, 3'd0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[6]  = '{4'd5,  8'h81, 8'h00, 3'd6, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0};
    tbl[7]  = '{4'd6,  8'h01, 8'h00, 3'd7, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[8]  = '{4'd2,  8'hF0, 8'h0F, 3'd1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[9]  = '{4'd3,  8'h0F, 8'hF0, 3'd2, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[10] = '{4'd1,  8'h03, 8'h05, 3'd3, 1'b1, 1'b0, 8'hFE, 1'b1, 1'b0};
    tbl[11] = '{4'd8,  8'hFF, 8'hFF, 3'd5, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    tbl[12] = '{4'd8,  8'h00, 8'h7F, 3'd6, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};

    rst_n = 1'b0;
    repeat (2) tick();
    check("rst_ready", bus.issue_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_wb_we", bus.wb_we, 0);
    check("rst_wb_data", bus.wb_data, 0);
    check("rst_wb_rd", bus.wb_rd, 0);
    check("rst_flags", {bus.flag_z, bus.flag_c, bus.illegal_op}, 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_release", bus.issue_ready, 0);
    tick();
    check("ready_first_edge", bus.issue_ready, 1);

    for (int i = 0; i < 13; i++) begin
      exec(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].we, tbl[i].ill, tbl[i].d, tbl[i].c, tbl[i].z);
    end

    bus.issue_valid = 1'b1; bus.op = OP_SUB; bus.a = 8'h05; bus.b = 8'h05; bus.rd_in = 3'd1;
    tick();
    check("b2b_we0", bus.wb_we, 1);
    check("b2b_data0", bus.wb_data, 8'h00);
    check("b2b_flags0", {bus.flag_z, bus.flag_c}, 2'b10);
    check("b2b_ready0", bus.issue_ready, 1);
    bus.op = OP_XOR; bus.a = 8'hAA; bus.b = 8'hFF; bus.rd_in = 3'd2;
    tick();
    bus.issue_valid = 1'b0;
    check("b2b_we1", bus.wb_we, 1);
    check("b2b_data1", bus.wb_data, 8'h55);
    check("b2b_rd1", bus.wb_rd, 3'd2);
    check("b2b_flags1", {bus.flag_z, bus.flag_c}, 2'b00);
    check("b2b_ready1", bus.issue_ready, 1);
    tick();
    check("b2b_we_end", bus.wb_we, 0);

    bus.issue_valid = 1'b1; bus.op = OP_MUL; bus.a = 8'h0F; bus.b = 8'h0F; bus.rd_in = 3'd5;
    tick();
    bus.issue_valid = 1'b0;
    repeat (3) tick();
    check("abort_busy_before", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_ready", bus.issue_ready, 0);
    check("abort_we_flags", {bus.wb_we, bus.flag_z, bus.flag_c}, 0);
    tick();
    rst_n = 1'b1;
    seen_we = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen_we = seen_we | bus.wb_we;
    end
    check("abort_no_wb", seen_we, 0);
    check("abort_ready_after", bus.issue_ready, 1);
    m_c = 1'b0; m_z = 1'b0;
    exec(OP_ADD, 8'h01, 8'h01, 3'd3, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 11));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rrd = 3'($urandom);
      model(rop, ra, rb, we, ill, d, c, z);
      exec(rop, ra, rb, rrd, we, ill, d, c, z);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
